// File: rtl/seven_seg_decoder_if.sv
// Bus between a multiplexed two-digit seven-segment driver and the capture-side decoder.
// The master drives the scan and observes the decoded pair; the decoder is the slave.
interface seven_seg_decoder_if;
  logic [1:0] digit_sel;
  logic [6:0] seven_sig;
  logic [3:0] o_tens;
  logic [3:0] o_ones;
  logic       o_valid;
  logic       o_err;
  logic       o_timeout;

  modport master (
    output digit_sel, seven_sig,
    input  o_tens, o_ones, o_valid, o_err, o_timeout
  );

  modport slave (
    input  digit_sel, seven_sig,
    output o_tens, o_ones, o_valid, o_err, o_timeout
  );
endinterface

// File: rtl/seven_seg_decoder.sv
// Samples a multiplexed two-digit seven-segment scan, filters short phases and glitches,
// decodes each digit back to BCD and reports completed tens/ones pairs with a valid strobe.
module seven_seg_decoder #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  seven_seg_decoder_if.slave  bus
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_HAVE_TENS = 2'd1;
  localparam logic [1:0]  S_HAVE_ONES = 2'd2;
  localparam logic [1:0]  SEL_TENS    = 2'b01;
  localparam logic [1:0]  SEL_ONES    = 2'b10;
  localparam logic [3:0]  STAB_MAX    = 4'(STABLE_CYCLES);
  localparam logic [3:0]  STAB_FIRE   = 4'(STABLE_CYCLES - 1);
  localparam logic [15:0] TO_MAX      = 16'(TIMEOUT_CYCLES);

  logic [1:0]  rSel_q, rSel_d;
  logic [6:0]  rSeg_q, rSeg_d;
  logic [3:0]  stabCnt_q, stabCnt_d;
  logic        armed_q, armed_d;
  logic [15:0] toCnt_q, toCnt_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  heldTens_q, heldTens_d;
  logic [3:0]  heldOnes_q, heldOnes_d;
  logic        errTens_q, errTens_d;
  logic        errOnes_q, errOnes_d;
  logic        pend_q, pend_d;
  logic [3:0]  pendTens_q, pendTens_d;
  logic [3:0]  pendOnes_q, pendOnes_d;
  logic        pendErr_q, pendErr_d;
  logic [3:0]  tens_q, ones_q;
  logic        valid_q, err_q;

  logic        selChange, anyChange, selValid, isTens;
  logic        armedNow, fire, capture, timeoutHit;
  logic [3:0]  segCode;
  logic        segErr;

  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = {1'b0, 4'd0};
      7'b1001111: res = {1'b0, 4'd1};
      7'b0010010: res = {1'b0, 4'd2};
      7'b0000110: res = {1'b0, 4'd3};
      7'b1001100: res = {1'b0, 4'd4};
      7'b0100100: res = {1'b0, 4'd5};
      7'b0100000: res = {1'b0, 4'd6};
      7'b0001111: res = {1'b0, 4'd7};
      7'b0000000: res = {1'b0, 4'd8};
      7'b0000100: res = {1'b0, 4'd9};
      7'b1111111: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'hE};
    endcase
    return res;
  endfunction

  // Change detection compares the sample being registered this edge with the held copy,
  // so a digit registered at edge k is captured at edge k+STABLE_CYCLES-1.
  always_comb begin
    rSel_d     = bus.digit_sel;
    rSeg_d     = bus.seven_sig;
    selChange  = (bus.digit_sel != rSel_q);
    anyChange  = selChange || (bus.seven_sig != rSeg_q);
    selValid   = (bus.digit_sel == SEL_TENS) || (bus.digit_sel == SEL_ONES);
    isTens     = (bus.digit_sel == SEL_TENS);

    stabCnt_d  = anyChange ? 4'd0 :
                 ((stabCnt_q == STAB_MAX) ? stabCnt_q : stabCnt_q + 4'd1);
    armedNow   = anyChange | armed_q;
    fire       = armedNow && selValid && (stabCnt_d == STAB_FIRE);
    armed_d    = selValid && armedNow && !fire;

    toCnt_d    = selChange ? 16'd0 :
                 ((toCnt_q == TO_MAX) ? toCnt_q : toCnt_q + 16'd1);
    timeoutHit = (toCnt_d == TO_MAX);
    timeout_d  = timeoutHit | (timeout_q & ~selChange);
    capture    = fire && !timeoutHit;

    {segErr, segCode} = decodeSeg(bus.seven_sig);
  end

  // Pair assembly; a stall discards whatever half-pair is held.
  always_comb begin
    state_d    = state_q;
    heldTens_d = heldTens_q;
    heldOnes_d = heldOnes_q;
    errTens_d  = errTens_q;
    errOnes_d  = errOnes_q;
    pend_d     = 1'b0;
    pendTens_d = pendTens_q;
    pendOnes_d = pendOnes_q;
    pendErr_d  = pendErr_q;
    if (timeoutHit) begin
      state_d = S_IDLE;
    end else if (capture) begin
      case (state_q)
        S_HAVE_TENS: begin
          if (isTens) begin
            heldTens_d = segCode;
            errTens_d  = segErr;
          end else begin
            pend_d     = 1'b1;
            pendTens_d = heldTens_q;
            pendOnes_d = segCode;
            pendErr_d  = errTens_q | segErr;
            state_d    = S_IDLE;
          end
        end
        S_HAVE_ONES: begin
          if (!isTens) begin
            heldOnes_d = segCode;
            errOnes_d  = segErr;
          end else begin
            pend_d     = 1'b1;
            pendTens_d = segCode;
            pendOnes_d = heldOnes_q;
            pendErr_d  = errOnes_q | segErr;
            state_d    = S_IDLE;
          end
        end
        default: begin
          if (isTens) begin
            heldTens_d = segCode;
            errTens_d  = segErr;
            state_d    = S_HAVE_TENS;
          end else begin
            heldOnes_d = segCode;
            errOnes_d  = segErr;
            state_d    = S_HAVE_ONES;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rSel_q     <= 2'b00;
      rSeg_q     <= 7'h7F;
      stabCnt_q  <= 4'd0;
      armed_q    <= 1'b0;
      toCnt_q    <= 16'd0;
      timeout_q  <= 1'b0;
      state_q    <= S_IDLE;
      heldTens_q <= 4'd0;
      heldOnes_q <= 4'd0;
      errTens_q  <= 1'b0;
      errOnes_q  <= 1'b0;
      pend_q     <= 1'b0;
      pendTens_q <= 4'd0;
      pendOnes_q <= 4'd0;
      pendErr_q  <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rSel_q     <= rSel_d;
      rSeg_q     <= rSeg_d;
      stabCnt_q  <= stabCnt_d;
      armed_q    <= armed_d;
      toCnt_q    <= toCnt_d;
      timeout_q  <= timeout_d;
      state_q    <= state_d;
      heldTens_q <= heldTens_d;
      heldOnes_q <= heldOnes_d;
      errTens_q  <= errTens_d;
      errOnes_q  <= errOnes_d;
      pend_q     <= pend_d;
      pendTens_q <= pendTens_d;
      pendOnes_q <= pendOnes_d;
      pendErr_q  <= pendErr_d;
      valid_q    <= pend_q;
      err_q      <= pend_q & pendErr_q;
      if (pend_q) begin
        tens_q <= pendTens_q;
        ones_q <= pendOnes_q;
      end
    end
  end

  assign bus.o_tens    = tens_q;
  assign bus.o_ones    = ones_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_err     = err_q;
  assign bus.o_timeout = timeout_q;

endmodule
